// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program-memory controller and its arbiter.
// The default sizes match the program memory macro.
package prog_mem_pkg;

  localparam int DATA_SIZE_DEF = 16;
  localparam int ADDR_SIZE_DEF = 4;
  localparam int RD_LATENCY    = 2;
  localparam int BURST_W       = 4;

  // Bit positions in the two-requester request/grant vectors
  localparam int REQ_FETCH = 0;
  localparam int REQ_LD    = 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/prog_mem_ctrl_if.sv
// Bus bundle between the fetch unit, the program loader, the controller and the program memory.
// The slave view is the controller; the master view is its surroundings.
interface prog_mem_ctrl_if
  import prog_mem_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) ();

  logic                 fetch_req;
  logic [ADDR_SIZE-1:0] fetch_addr;
  logic                 fetch_gnt;
  logic                 fetch_rvalid;
  logic [DATA_SIZE-1:0] fetch_rdata;

  logic                 ld_session;
  logic                 ld_req;
  logic [ADDR_SIZE-1:0] ld_addr;
  logic [DATA_SIZE-1:0] ld_data;
  logic                 ld_gnt;
  logic                 ld_done;

  logic                 mem_w;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic [DATA_SIZE-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, ld_session, ld_req, ld_addr, ld_data, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, ld_gnt, ld_done, mem_w, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, ld_session, ld_req, ld_addr, ld_data, mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, ld_gnt, ld_done, mem_w, mem_addr, mem_wdata
  );

endinterface

// File: rtl/prog_mem_arb.sv
// Fixed-priority arbiter (loader first) with a burst counter that lets a pending
// fetch through after MAX_BURST consecutive loader grants.
module prog_mem_arb
  import prog_mem_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic [1:0] allow,
  input  logic       clr,
  output logic [1:0] gnt
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  logic [BURST_W-1:0] burst_q, burst_d;
  logic [1:0]         req_eff;

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req_eff = req & allow;
    gnt     = '0;
    if (req_eff[REQ_LD] && !(req_eff[REQ_FETCH] && burst_q == BURST_MAX)) begin
      gnt[REQ_LD] = 1'b1;
    end else if (req_eff[REQ_FETCH]) begin
      gnt[REQ_FETCH] = 1'b1;
    end

    burst_d = burst_q;
    if (clr || !req[REQ_FETCH] || gnt[REQ_FETCH]) begin
      burst_d = '0;
    end else if (gnt[REQ_LD] && burst_q != BURST_MAX) begin
      burst_d = burst_q + 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/prog_mem_ctrl.sv
// Program-memory sequencer: shares the single-port memory between fetch and loader,
// registers memory commands, tracks read latency and runs the load-session FSM.
module prog_mem_ctrl
  import prog_mem_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rstn,
  prog_mem_ctrl_if.slave  bus
);

  state_e                state_q, state_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic                  mem_w_q, mem_w_d;
  logic [ADDR_SIZE-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_SIZE-1:0]  mem_wdata_q, mem_wdata_d;
  logic                  ld_done_q, ld_done_d;

  logic [1:0] allow;
  logic [1:0] gnt;
  logic       arb_clr;

  prog_mem_arb #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .req   ({bus.ld_req, bus.fetch_req}),
    .allow (allow),
    .clr   (arb_clr),
    .gnt   (gnt)
  );

  always_comb begin
    state_d   = state_q;
    allow     = '0;
    arb_clr   = 1'b0;
    ld_done_d = 1'b0;
    case (state_q)
      RUN: begin
        // A session request freezes all grants until in-flight reads have returned
        if (bus.ld_session) begin
          if (vld_q == '0) state_d = LOAD;
        end else begin
          allow = 2'b11;
        end
      end
      LOAD: begin
        if (bus.ld_session) begin
          allow[REQ_LD] = 1'b1;
        end else begin
          state_d   = DRAIN;
          ld_done_d = 1'b1;
        end
      end
      DRAIN: begin
        state_d = RUN;
        arb_clr = 1'b1;
      end
      default: state_d = RUN;
    endcase
    // Nothing is accepted while reset is held, even though state is still valid
    if (!rstn) allow = '0;
  end

  always_comb begin
    mem_w_d     = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (gnt[REQ_FETCH]) begin
      mem_addr_d = bus.fetch_addr;
    end else if (gnt[REQ_LD]) begin
      mem_w_d     = 1'b1;
      mem_addr_d  = bus.ld_addr;
      mem_wdata_d = bus.ld_data;
    end
    vld_d = {vld_q[RD_LATENCY-2:0], gnt[REQ_FETCH]};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= RUN;
      vld_q       <= '0;
      mem_w_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      mem_w_q     <= mem_w_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_done_q   <= ld_done_d;
    end
  end

  assign bus.fetch_gnt    = gnt[REQ_FETCH];
  assign bus.ld_gnt       = gnt[REQ_LD];
  assign bus.fetch_rvalid = vld_q[RD_LATENCY-1];
  assign bus.fetch_rdata  = vld_q[RD_LATENCY-1] ? bus.mem_rdata : '0;
  assign bus.ld_done      = ld_done_q;
  assign bus.mem_w        = mem_w_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Scoreboard bench for prog_mem_ctrl: stimulus pushes expected fetch data and issue cycle,
// a negedge monitor pops and compares on every fetch_rvalid.
module tb_prog_mem_ctrl;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  prog_mem_ctrl_if #(.DATA_SIZE(16), .ADDR_SIZE(4)) bus ();

  prog_mem_ctrl #(.DATA_SIZE(16), .ADDR_SIZE(4), .MAX_BURST(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Program memory model: registered read, write enable W, never reset
  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (bus.mem_w) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   ld_done_cnt = 0;
  int   last_wait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1 && bus.fetch_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("fetch_rdata", 32'(bus.fetch_rdata), 32'(e.data));
        check("fetch_latency", cyc, e.cyc + 2);
      end
    end
    if (bus.ld_done === 1'b1) ld_done_cnt++;
  end

  // All tasks start and end at posedge+1
  task automatic fetch(input logic [3:0] a, input logic [15:0] exp);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.fetch_gnt === 1'b1) begin
        sb.push_back('{data: exp, cyc: cyc});
        last_wait = k;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    last_wait = -1;
    check("fetch_gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic ld_write(input logic [3:0] a, input logic [15:0] d);
    bus.ld_req  = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ld_gnt === 1'b1) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    check("ld_gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] <= 16'hC000 + 16'(i);
    mem[5] <= 16'hA5A5;

    rstn           = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 4'd5;
    bus.ld_session = 1'b0;
    bus.ld_req     = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;

    // Reset held with a pending fetch: everything quiet
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
      check("rst_ld_gnt", 32'(bus.ld_gnt), 32'd0);
      check("rst_mem_w", 32'(bus.mem_w), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      check("rst_rvalid", 32'(bus.fetch_rvalid), 32'd0);
      check("rst_ld_done", 32'(bus.ld_done), 32'd0);
    end
    @(posedge clk); #1;
    rstn = 1'b1;

    // First fetch after release, then a back-to-back sweep of all addresses
    fetch(4'd5, 16'hA5A5);
    check("gnt_after_reset_wait", 32'(last_wait), 32'd0);
    for (int i = 0; i < 16; i++) fetch(4'(i), (i == 5) ? 16'hA5A5 : 16'hC000 + 16'(i));
    bus.fetch_req = 1'b0;
    idle(2);

    // Patch write followed by a fetch of the same address in the next cycle
    ld_write(4'd3, 16'h1234);
    bus.ld_req = 1'b0;
    fetch(4'd3, 16'h1234);
    check("wr_rd_fetch_wait", 32'(last_wait), 32'd0);
    bus.fetch_req = 1'b0;
    idle(3);

    // Both requesters held: L,L,L,L,F repeating
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 4'd7;
    bus.ld_req     = 1'b1;
    bus.ld_addr    = 4'd9;
    bus.ld_data    = 16'hBEEF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("starve_fetch_gnt", 32'(bus.fetch_gnt), 32'(k % 5 == 4));
      check("starve_ld_gnt", 32'(bus.ld_gnt), 32'(k % 5 != 4));
      if (bus.fetch_gnt === 1'b1) sb.push_back('{data: 16'hC007, cyc: cyc});
      @(posedge clk); #1;
    end
    bus.fetch_req = 1'b0;
    bus.ld_req    = 1'b0;
    idle(4);

    // Session entered with two fetches in flight
    fetch(4'd1, 16'hC001);
    fetch(4'd2, 16'hC002);
    bus.fetch_req  = 1'b0;
    bus.ld_session = 1'b1;
    bus.ld_req     = 1'b1;
    bus.ld_addr    = 4'd0;
    bus.ld_data    = 16'h0100;
    @(negedge clk);
    check("session_wait_ld_gnt", 32'(bus.ld_gnt), 32'd0);
    check("session_wait_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      ld_write(4'(i), 16'h0100 + 16'(i));
      if (i == 0) check("session_pipe_drained", 32'(sb.size()), 32'd0);
    end

    // Drop the session with a fetch already waiting: transition cycle, DRAIN, then RUN
    bus.ld_session = 1'b0;
    bus.ld_req     = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 4'd0;
    @(negedge clk);
    check("exit_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
    check("exit_ld_done", 32'(bus.ld_done), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
    check("drain_ld_done", 32'(bus.ld_done), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      fetch(4'(i), 16'h0100 + 16'(i));
      if (i == 0) check("post_drain_fetch_wait", 32'(last_wait), 32'd0);
    end
    bus.fetch_req = 1'b0;
    idle(4);
    check("ld_done_pulses", 32'(ld_done_cnt), 32'd1);

    // Reset while the loader is presenting write 7
    bus.ld_session = 1'b1;
    for (int i = 0; i < 7; i++) ld_write(4'(i), 16'h0200 + 16'(i));
    bus.ld_addr = 4'd7;
    bus.ld_data = 16'h0207;
    rstn        = 1'b0;
    @(negedge clk);
    check("midrst_ld_gnt", 32'(bus.ld_gnt), 32'd0);
    @(posedge clk); #1;
    bus.ld_session = 1'b0;
    bus.ld_req     = 1'b0;
    @(negedge clk);
    check("midrst_mem_w", 32'(bus.mem_w), 32'd0);
    check("midrst_ld_done", 32'(bus.ld_done), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fetch(4'(i), (i < 7) ? 16'h0200 + 16'(i) : 16'h0107);
      if (i == 0) check("midrst_run_fetch_wait", 32'(last_wait), 32'd0);
    end
    bus.fetch_req = 1'b0;
    idle(4);
    check("midrst_no_ld_done", 32'(ld_done_cnt), 32'd1);

    for (int k = 0; k < 10 && sb.size() != 0; k++) idle(1);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
